// File: rtl/axi_burst_master.sv
// axi_burst_master: single-outstanding AXI3 burst master.
// Turns one command (write or read, id, address, length) into a complete
// AW/W/B or AR/R transaction. Write beats are passed through from the source
// stream and read beats are passed through to the sink stream. A registered
// done pulse reports the final response and a protocol-error flag.
module axi_burst_master #(
    parameter int ID_W   = 4,
    parameter int DATA_W = 32
) (
    input  logic              aclk,
    input  logic              aresetn,
    // command port
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ID_W-1:0]   cmd_id,
    input  logic [31:0]       cmd_addr,
    input  logic [3:0]        cmd_len,
    // write-data source
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_valid,
    output logic              wr_ready,
    // read-data sink
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic              rd_last,
    // completion
    output logic              done,
    output logic [1:0]        done_resp,
    output logic              done_err,
    // AW channel
    output logic [ID_W-1:0]   awid,
    output logic [31:0]       awaddr,
    output logic [3:0]        awlen,
    output logic [2:0]        awsize,
    output logic [1:0]        awburst,
    output logic [1:0]        awlock,
    output logic [3:0]        awcache,
    output logic [2:0]        awprot,
    output logic              awvalid,
    input  logic              awready,
    // W channel
    output logic [ID_W-1:0]   wid,
    output logic [DATA_W-1:0] wdata,
    output logic [3:0]        wstrb,
    output logic              wlast,
    output logic              wvalid,
    input  logic              wready,
    // B channel
    input  logic [ID_W-1:0]   bid,
    input  logic [1:0]        bresp,
    input  logic              bvalid,
    output logic              bready,
    // AR channel
    output logic [ID_W-1:0]   arid,
    output logic [31:0]       araddr,
    output logic [3:0]        arlen,
    output logic [2:0]        arsize,
    output logic [1:0]        arburst,
    output logic [1:0]        arlock,
    output logic [3:0]        arcache,
    output logic [1:0]        arprot,
    output logic              arvalid,
    input  logic              arready,
    // R channel
    input  logic [ID_W-1:0]   rid,
    input  logic [DATA_W-1:0] rdata,
    input  logic [1:0]        rresp,
    input  logic              rlast,
    input  logic              rvalid,
    output logic              rready
);

    // state | meaning
    // IDLE  | waiting for a command, cmd_ready high
    // AW    | write address presented, waiting for awready
    // WD    | streaming write beats from the source
    // BR    | waiting for the write response
    // AR    | read address presented, waiting for arready
    // RD    | streaming read beats to the sink
    typedef enum logic [2:0] {
        S_IDLE,
        S_AW,
        S_WD,
        S_BR,
        S_AR,
        S_RD
    } state_t;

    state_t          state;
    state_t          state_nxt;

    logic [ID_W-1:0] id_q;
    logic [31:0]     addr_q;
    logic [3:0]      len_q;
    logic [3:0]      beat_q;
    logic [1:0]      resp_acc;
    logic            err_acc;

    logic            beat_final;
    logic            w_hs;
    logic            r_hs;
    logic [1:0]      resp_max;
    logic            r_beat_err;

    assign beat_final = (beat_q == len_q);
    assign w_hs       = (state == S_WD) && wr_valid && wready;
    assign r_hs       = (state == S_RD) && rvalid && rd_ready;
    assign resp_max   = (rresp > resp_acc) ? rresp : resp_acc;
    // rlast must coincide exactly with the final beat, and every beat must carry our id
    assign r_beat_err = (rid != id_q) || (rlast != beat_final);

    // address/control fields come straight from the latched command
    assign awid    = id_q;
    assign awaddr  = addr_q;
    assign awlen   = len_q;
    assign awsize  = 3'b010;
    assign awburst = 2'b01;
    assign awlock  = 2'b00;
    assign awcache = 4'h0;
    assign awprot  = 3'b000;
    assign wid     = id_q;
    assign wdata   = wr_data;
    assign wstrb   = 4'hF;
    assign arid    = id_q;
    assign araddr  = addr_q;
    assign arlen   = len_q;
    assign arsize  = 3'b010;
    assign arburst = 2'b01;
    assign arlock  = 2'b00;
    assign arcache = 4'h0;
    assign arprot  = 2'b00;
    assign rd_data = rdata;

    // state register; reset aborts any transaction in flight
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // next state and per-state handshake outputs
    always_comb begin
        state_nxt = state;
        cmd_ready = 1'b0;
        awvalid   = 1'b0;
        arvalid   = 1'b0;
        wvalid    = 1'b0;
        wr_ready  = 1'b0;
        wlast     = 1'b0;
        bready    = 1'b0;
        rready    = 1'b0;
        rd_valid  = 1'b0;
        rd_last   = 1'b0;
        case (state)
            S_IDLE: begin
                // reset sits in IDLE, so gate the ready with reset itself
                cmd_ready = aresetn;
                if (cmd_valid && cmd_ready) begin
                    state_nxt = cmd_write ? S_AW : S_AR;
                end
            end
            S_AW: begin
                awvalid = 1'b1;
                if (awready) begin
                    state_nxt = S_WD;
                end
            end
            S_WD: begin
                wvalid   = wr_valid;
                wr_ready = wready;
                wlast    = beat_final;
                if (w_hs && beat_final) begin
                    state_nxt = S_BR;
                end
            end
            S_BR: begin
                bready = 1'b1;
                if (bvalid) begin
                    state_nxt = S_IDLE;
                end
            end
            S_AR: begin
                arvalid = 1'b1;
                if (arready) begin
                    state_nxt = S_RD;
                end
            end
            S_RD: begin
                rready   = rd_ready;
                rd_valid = rvalid;
                rd_last  = beat_final;
                if (r_hs && beat_final) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // command latch, beat counter, response accumulation and done reporting
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            id_q      <= '0;
            addr_q    <= '0;
            len_q     <= '0;
            beat_q    <= '0;
            resp_acc  <= '0;
            err_acc   <= 1'b0;
            done      <= 1'b0;
            done_resp <= '0;
            done_err  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        id_q     <= cmd_id;
                        addr_q   <= cmd_addr & 32'hFFFF_FFFC;
                        len_q    <= cmd_len;
                        beat_q   <= '0;
                        resp_acc <= '0;
                        err_acc  <= 1'b0;
                    end
                end
                S_WD: begin
                    if (w_hs) begin
                        beat_q <= beat_q + 4'd1;
                    end
                end
                S_BR: begin
                    if (bvalid) begin
                        done      <= 1'b1;
                        done_resp <= bresp;
                        done_err  <= (bid != id_q);
                    end
                end
                S_RD: begin
                    if (r_hs) begin
                        beat_q   <= beat_q + 4'd1;
                        resp_acc <= resp_max;
                        err_acc  <= err_acc | r_beat_err;
                        if (beat_final) begin
                            done      <= 1'b1;
                            done_resp <= resp_max;
                            done_err  <= err_acc | r_beat_err;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/axi_burst_master.md
Name: axi_burst_master

Overview:
- Single-outstanding AXI3-style burst master; the upstream stage that drives our AXI slave model.
- Converts one command (write or read, id, address, length) into a full AW/W/B or AR/R transaction.
- Write data is streamed in from a source port and read data is streamed out to a sink port.
- Reports completion status per command.

Parameters:
- ID_W, 4, width of AXI id fields and cmd_id.
- DATA_W, 32, data width; fixed at 32 (wstrb 4 bits, awsize/arsize 3'b010).

Ports:
- aclk  input  1  clock; all logic on the rising edge.
- aresetn  input  1  asynchronous active-low reset.
- cmd_valid  input  1  command request.
- cmd_ready  output  1  command accepted when high with cmd_valid.
- cmd_write  input  1  1 = write burst, 0 = read burst.
- cmd_id  input  4  transaction id.
- cmd_addr  input  32  start byte address; bits [1:0] ignored and driven as 0.
- cmd_len  input  4  beats minus 1 (AXI3 encoding, 1..16 beats).
- wr_data, wr_valid, wr_ready  in/in/out  32/1/1  write-data source stream.
- rd_data, rd_valid, rd_ready, rd_last  out/out/in/out  32/1/1/1  read-data sink stream.
- done  output  1  one-cycle pulse at end of command.
- done_resp  output  2  final response: bresp, or worst (max) rresp over the burst.
- done_err  output  1  protocol error flag, valid with done.
- awid, awaddr, awlen  output  4/32/4  write address fields.
- awsize, awburst, awlock, awcache, awprot  output  3/2/2/4/3  constants: 3'b010, 2'b01 (INCR), 0, 0, 0.
- awvalid, awready  out/in  1/1  AW handshake.
- wid, wdata, wstrb, wlast, wvalid, wready  out/out/out/out/out/in  4/32/4/1/1/1  W channel; wstrb constant 4'hF.
- bid, bresp, bvalid, bready  in/in/in/out  4/2/1/1  B channel.
- arid, araddr, arlen  output  4/32/4  read address fields.
- arsize, arburst, arlock, arcache, arprot  output  3/2/2/4/2  constants: 3'b010, 2'b01, 0, 0, 0 (arprot is 2 bits to match the slave).
- arvalid, arready  out/in  1/1  AR handshake.
- rid, rdata, rresp, rlast, rvalid, rready  in/in/in/in/in/out  4/32/2/1/1/1  R channel.

Behaviour:

Reset:
- While aresetn is low, all registered outputs are 0; cmd_ready, every *valid and every *ready are 0.
- State is forced to IDLE. Asserting reset mid-transaction aborts it immediately: no done pulse and no further handshakes.

States: IDLE, AW, WD, BR, AR, RD.

IDLE:
- cmd_ready=1.
- On cmd_valid&&cmd_ready, latch id, addr (low 2 bits zeroed), len and write.
- Next state is AW if write, else AR. cmd_ready is 0 in every other state.

AW / AR:
- awvalid (or arvalid) is registered high on the cycle after acceptance.
- All address and control fields stay stable until awready (arready) is sampled high on a rising edge.
- On that edge, valid drops and the FSM moves to WD (RD).
- There is no early deassertion.

WD:
- wvalid=wr_valid, wdata=wr_data, wr_ready=wready (combinational pass-through, gated by state). wid is the latched id.
- A 4-bit beat counter starts at 0; wlast=(beat==len).
- Each wvalid&&wready edge increments the counter. The handshake with wlast=1 moves to BR.
- W never starts before the AW handshake completes.
- len=0 means wlast is high on the first beat.

BR:
- bready=1.
- On bvalid, capture bresp into done_resp and set done_err=(bid!=latched id).
- Pulse done for one cycle, return to IDLE, deassert bready the following cycle.

RD:
- rready=rd_ready; rd_valid=rvalid; rd_data=rdata; rd_last=(beat==len).
- The counter increments on each rvalid&&rready.
- done_resp accumulates the maximum rresp seen.
- The burst ends on the handshake where beat==len.
- done_err=1 if any beat has rid!=id, if rlast is set before the final beat, or if rlast is missing on the final beat.
- Then pulse done and return to IDLE.

Other rules:
- done, done_resp and done_err are registered. done_resp and done_err hold until the next done.
- Address increment and 4 KB boundary checks are the command issuer's responsibility; the block does not split bursts.
- A new command is accepted no earlier than the cycle after done.

Test Plan:
1. Write id=3, addr=0x100, len=3, data 0x11111111..0x44444444, slave returns bresp=0 -> awlen=3, four W beats with wlast only on the 4th, done pulse with done_resp=0 and done_err=0.
2. Read id=3, addr=0x100, len=3 after test 1 -> rd_data=0x11111111..0x44444444 in order, rd_last on beat 4, done_resp=0.
3. Write len=0, awready delayed 5 cycles, wready toggling -> awvalid held 5 cycles with stable awaddr; a single beat with wlast=1; exactly one done.
4. Read len=1 with rd_ready low for 3 cycles mid-burst -> rready follows rd_ready; no beat is lost or duplicated; 2 beats delivered.
5. Read where the slave returns rresp=2'b10 on beat 2 of 4, and/or rlast on beat 3 -> done_resp=2'b10; done_err=1 in the rlast case.
6. Assert aresetn low during WD on beat 2 -> all valids/readies are 0 asynchronously; no done; after release cmd_ready=1 and a fresh write completes normally.
